// File: rtl/rr_mux_arbiter_8.sv
// Round-robin arbiter sharing one registered output channel among 8 requesters.
// The winner's word is captured into an output register and offered downstream
// with a valid/ready handshake; back-to-back grants sustain one word per cycle.
module rr_mux_arbiter_8 #(
   parameter int unsigned DATA_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [7:0]            req,
   input  logic [8*DATA_W-1:0]   in_data,
   output logic [7:0]            ack,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_W-1:0]     out_data,
   output logic [2:0]            out_sel,
   output logic                  busy
);

   typedef enum logic [0:0] {StIdle, StHold} state_e;

   state_e            state_q, state_d;
   logic [2:0]        ptr_q;
   logic [2:0]        sel_q;
   logic [DATA_W-1:0] data_q;
   logic [7:0]        ack_q;

   logic [2:0]        win;
   logic              any_req;
   logic              grant;

   assign any_req = |req;

   // Rotating priority search starting at ptr_q, wrapping modulo 8.
   always_comb begin
      logic [2:0] idx;
      logic       found;
      win   = 3'd0;
      found = 1'b0;
      idx   = 3'd0;
      for (int k = 0; k < 8; k++) begin
         idx = ptr_q + 3'(k);
         if (!found && req[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and grant decision; a grant in HOLD needs the current word accepted.
   always_comb begin
      state_d = state_q;
      grant   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (any_req) begin
               grant   = 1'b1;
               state_d = StHold;
            end
         end
         StHold: begin
            if (out_ready) begin
               if (any_req) begin
                  grant = 1'b1;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Capture the winner's word, index and ack pulse; advance the pointer past it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
         sel_q  <= 3'd0;
         ptr_q  <= 3'd0;
         ack_q  <= 8'd0;
      end else if (grant) begin
         data_q <= in_data[32'(win) * DATA_W +: DATA_W];
         sel_q  <= win;
         ptr_q  <= win + 3'd1;
         ack_q  <= 8'd1 << win;
      end else begin
         ack_q  <= 8'd0;
      end
   end

   // Outputs come straight from registers; valid is the HOLD state itself.
   always_comb begin
      out_valid = (state_q == StHold);
      busy      = (state_q == StHold);
      out_data  = data_q;
      out_sel   = sel_q;
      ack       = ack_q;
   end

endmodule

// File: tb/tb_rr_mux_arbiter_8.sv
// Directed self-checking bench for rr_mux_arbiter_8 with hand-computed expectations.
module tb_rr_mux_arbiter_8;

   localparam int unsigned DATA_W = 8;

   logic                clk;
   logic                rst_n;
   logic [7:0]          req;
   logic [8*DATA_W-1:0] in_data;
   logic [7:0]          ack;
   logic                out_valid;
   logic                out_ready;
   logic [DATA_W-1:0]   out_data;
   logic [2:0]          out_sel;
   logic                busy;

   int n_checks = 0;
   int n_fail   = 0;

   rr_mux_arbiter_8 #(.DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .in_data   (in_data),
      .ack       (ack),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_words(input logic [7:0] base);
      for (int i = 0; i < 8; i++) in_data[i*DATA_W +: DATA_W] = base + 8'(i);
   endtask

   task automatic set_word(input int idx, input logic [7:0] val);
      in_data[idx*DATA_W +: DATA_W] = val;
   endtask

   task automatic check_grant(input string tag, input int idx, input logic [7:0] word);
      check({tag, "_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_sel"},   64'(out_sel),   64'(idx));
      check({tag, "_ack"},   64'(ack),       64'(8'd1 << idx));
      check({tag, "_data"},  64'(out_data),  64'(word));
   endtask

   initial begin
      int fair_seq [4];
      fair_seq = '{4, 0, 4, 0};

      // Reset with all requests high.
      rst_n     = 1'b0;
      req       = 8'hFF;
      out_ready = 1'b1;
      load_words(8'h10);
      step();
      step();
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_ack",   64'(ack),       64'd0);
      check("rst_data",  64'(out_data),  64'd0);
      check("rst_sel",   64'(out_sel),   64'd0);
      check("rst_busy",  64'(busy),      64'd0);

      // Release: grants 0..7,0 back to back.
      rst_n = 1'b1;
      for (int i = 0; i < 9; i++) begin
         step();
         check_grant($sformatf("seq%0d", i), i % 8, 8'h10 + 8'(i % 8));
         check($sformatf("seq%0d_busy", i), 64'(busy), 64'd1);
      end
      req = 8'h00;
      step();
      check("drain_valid", 64'(out_valid), 64'd0);
      check("drain_ack",   64'(ack),       64'd0);
      check("drain_sel",   64'(out_sel),   64'd0);
      check("drain_data",  64'(out_data),  64'h10);

      // Single requester 5 (ptr=1).
      set_word(5, 8'hA5);
      req = 8'h20;
      step();
      check_grant("single", 5, 8'hA5);
      req = 8'h00;
      step();
      check("single_drop_valid", 64'(out_valid), 64'd0);
      check("single_drop_ack",   64'(ack),       64'd0);

      // Backpressure on requester 3 (ptr=6).
      out_ready = 1'b0;
      set_word(3, 8'h3C);
      req = 8'h08;
      step();
      check_grant("bp", 3, 8'h3C);
      for (int i = 0; i < 4; i++) begin
         req = 8'hFF;
         load_words(8'h50 + 8'(i * 16));
         step();
         check($sformatf("bp_hold%0d_data", i),  64'(out_data),  64'h3C);
         check($sformatf("bp_hold%0d_sel", i),   64'(out_sel),   64'd3);
         check($sformatf("bp_hold%0d_ack", i),   64'(ack),       64'd0);
         check($sformatf("bp_hold%0d_valid", i), 64'(out_valid), 64'd1);
      end
      load_words(8'h10);
      out_ready = 1'b1;
      step();
      check_grant("bp_next", 4, 8'h14);
      req = 8'h00;
      step();
      check("bp_idle", 64'(out_valid), 64'd0);

      // Wrap-around: grant 6 (ptr=5), then req=41 picks 0 then 6.
      req = 8'h40;
      step();
      check_grant("wrap6", 6, 8'h16);
      req = 8'h41;
      step();
      check_grant("wrap0", 0, 8'h10);
      step();
      check_grant("wrap6b", 6, 8'h16);
      req = 8'h00;
      step();
      check("wrap_idle", 64'(out_valid), 64'd0);

      // Fairness: requester 0 continuous, then requester 4 joins (ptr=7).
      req = 8'h01;
      step();
      check_grant("fair_a", 0, 8'h10);
      step();
      check_grant("fair_b", 0, 8'h10);
      req = 8'h11;
      for (int i = 0; i < 4; i++) begin
         step();
         check_grant($sformatf("fair%0d", i), fair_seq[i], 8'h10 + 8'(fair_seq[i]));
      end
      req = 8'h00;
      step();
      check("fair_idle", 64'(out_valid), 64'd0);

      // Async reset mid-HOLD (ptr=1, so 0x24 picks 2 and leaves ptr=3).
      out_ready = 1'b0;
      req = 8'h24;
      step();
      check_grant("pre_rst", 2, 8'h12);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_valid", 64'(out_valid), 64'd0);
      check("arst_busy",  64'(busy),      64'd0);
      check("arst_ack",   64'(ack),       64'd0);
      check("arst_data",  64'(out_data),  64'd0);
      check("arst_sel",   64'(out_sel),   64'd0);
      #2;
      rst_n = 1'b1;
      out_ready = 1'b1;
      step();
      check_grant("post_rst", 2, 8'h12);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
